// File: rtl/fpu_seq.sv
// fpu_seq: multicycle FP execute unit (FADD, FMUL, FADDH, FMULH) with truncating rounding.
// Optional macro FPU_FLAGS_EN adds flags[3:0] = {invalid, overflow, underflow, inexact}.
module fpu_seq #(
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
`ifdef FPU_FLAGS_EN
   output logic [3:0]  flags,
`endif
   output logic [31:0] result
);
   // state  | meaning
   // IDLE   | waiting for start (ignored while done is high)
   // UNPACK | split latched operands, detect NaN/zero, seed multiplier
   // ALIGN  | order by magnitude, right-shift smaller mantissa
   // ADD    | add/subtract magnitudes
   // MUL    | iterative shift-add mantissa product
   // NORM   | fix carry-out or shift left until hidden bit set
   // PACK   | assemble and register result, pulse done
   localparam int K = MUL_BITS_PER_CYCLE;
   localparam logic [4:0] MUL_LAST_S = 5'(24 / K - 1);
   localparam logic [4:0] MUL_LAST_H = 5'((11 + K - 1) / K - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_MUL, S_NORM, S_PACK
   } state_t;

   state_t state, state_n;
   logic   accept;

   logic               half_q, mul_q;
   logic [31:0]        a_q, b_q;
   logic               sa_q, sb_q, sign_r, nan_q, sub_q;
   logic [7:0]         ea_q, eb_q;
   logic [23:0]        ma_q, mb_q;
   logic signed [11:0] exp_r;
   logic [47:0]        m, mcand, partial;
   logic [23:0]        mq;
   logic [4:0]         cnt;

   logic               ua_s, ub_s, ua_nan, ub_nan;
   logic [7:0]         ua_e, ub_e, emax;
   logic [23:0]        ua_m, ub_m;
   logic signed [11:0] emax_s;

   always_comb begin
      if (half_q) begin
         ua_s = a_q[15];
         ua_e = {3'b0, a_q[14:10]};
         ua_m = {13'b0, 1'b1, a_q[9:0]};
         ub_s = b_q[15];
         ub_e = {3'b0, b_q[14:10]};
         ub_m = {13'b0, 1'b1, b_q[9:0]};
         emax = 8'd31;
      end else begin
         ua_s = a_q[31];
         ua_e = a_q[30:23];
         ua_m = {1'b1, a_q[22:0]};
         ub_s = b_q[31];
         ub_e = b_q[30:23];
         ub_m = {1'b1, b_q[22:0]};
         emax = 8'd255;
      end
      ua_nan = (ua_e == emax);
      ub_nan = (ub_e == emax);
      // zero and denormal inputs are flushed
      if (ua_e == 8'd0) ua_m = '0;
      if (ub_e == 8'd0) ub_m = '0;
      emax_s = $signed({4'b0, emax});
   end

   logic        swap;
   logic [7:0]  e_big, d;
   logic [23:0] m_big, m_small, m_shift;

   always_comb begin
      swap    = {eb_q, mb_q} > {ea_q, ma_q};
      e_big   = swap ? eb_q : ea_q;
      m_big   = swap ? mb_q : ma_q;
      m_small = swap ? ma_q : mb_q;
      d       = swap ? (eb_q - ea_q) : (ea_q - eb_q);
      if (d >= (half_q ? 8'd13 : 8'd26)) m_shift = '0;
      else                              m_shift = m_small >> d;
   end

   logic [24:0] sum;
   assign sum = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

   always_comb begin
      partial = '0;
      for (int i = 0; i < K; i++)
         if (mq[i]) partial = partial + (mcand << i);
   end

   logic [31:0] pack_v;
   always_comb begin
      if (nan_q)
         pack_v = half_q ? 32'h0000_7E00 : 32'h7FC0_0000;
      else if (m == '0 || exp_r <= 12'sd0)
         pack_v = half_q ? {16'b0, sign_r, 15'b0} : {sign_r, 31'b0};
      else if (exp_r >= emax_s)
         pack_v = half_q ? {16'b0, sign_r, 5'h1F, 10'b0} : {sign_r, 8'hFF, 23'b0};
      else
         pack_v = half_q ? {16'b0, sign_r, exp_r[4:0], m[45:36]}
                         : {sign_r, exp_r[7:0], m[45:23]};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      busy    = (state != S_IDLE);
      case (state)
         S_IDLE:
            if (start && !done) begin
               accept  = 1'b1;
               state_n = S_UNPACK;
            end
         S_UNPACK:
            if (ua_nan || ub_nan)               state_n = S_PACK;
            else if (!mul_q)                    state_n = S_ALIGN;
            else if (ua_m == '0 || ub_m == '0)  state_n = S_PACK;
            else                                state_n = S_MUL;
         S_ALIGN: state_n = S_ADD;
         S_ADD:   state_n = S_NORM;
         S_MUL:   if (cnt == 5'd0) state_n = S_NORM;
         S_NORM:  if (m[47] || m[46] || m == '0) state_n = S_PACK;
         S_PACK:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         done   <= 1'b0;
         half_q <= 1'b0;
         mul_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         sign_r <= 1'b0;
         nan_q  <= 1'b0;
         sub_q  <= 1'b0;
         ea_q   <= '0;
         eb_q   <= '0;
         ma_q   <= '0;
         mb_q   <= '0;
         exp_r  <= '0;
         m      <= '0;
         mcand  <= '0;
         mq     <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE:
               if (accept) begin
                  a_q    <= a;
                  b_q    <= b;
                  half_q <= op[1];
                  mul_q  <= op[0];
               end
            S_UNPACK: begin
               sa_q   <= ua_s;
               sb_q   <= ub_s;
               ea_q   <= ua_e;
               eb_q   <= ub_e;
               ma_q   <= ua_m;
               mb_q   <= ub_m;
               nan_q  <= ua_nan | ub_nan;
               sign_r <= ua_s ^ ub_s;
               m      <= '0;
               exp_r  <= $signed({4'b0, ua_e}) + $signed({4'b0, ub_e})
                         - (half_q ? 12'sd15 : 12'sd127);
               mcand  <= {24'b0, ua_m};
               mq     <= ub_m;
               cnt    <= half_q ? MUL_LAST_H : MUL_LAST_S;
            end
            S_ALIGN: begin
               ma_q   <= m_big;
               mb_q   <= m_shift;
               sign_r <= swap ? sb_q : sa_q;
               sub_q  <= sa_q ^ sb_q;
               exp_r  <= $signed({4'b0, e_big});
            end
            S_ADD: begin
               // hidden bit lands at 46 for both formats so NORM/PACK are shared
               m <= half_q ? ({23'b0, sum} << 36) : ({23'b0, sum} << 23);
               if (sub_q && sum == '0) sign_r <= 1'b0;
            end
            S_MUL: begin
               m     <= (cnt == 5'd0 && half_q) ? ((m + partial) << 26) : (m + partial);
               mcand <= mcand << K;
               mq    <= mq >> K;
               cnt   <= cnt - 5'd1;
            end
            S_NORM:
               if (m[47]) begin
                  m     <= m >> 1;
                  exp_r <= exp_r + 12'sd1;
               end else if (m != '0 && !m[46]) begin
                  m     <= m << 1;
                  exp_r <= exp_r - 12'sd1;
               end
            S_PACK: begin
               result <= pack_v;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef FPU_FLAGS_EN
   logic inex_q, lost_al, lost_pk, ovf, unf;

   assign lost_al = (d >= (half_q ? 8'd13 : 8'd26)) ? (m_small != '0)
                                                   : ((m_shift << d) != m_small);
   assign lost_pk = half_q ? (m[35:0] != '0) : (m[22:0] != '0);
   assign ovf     = !nan_q && m != '0 && exp_r >= emax_s;
   assign unf     = !nan_q && m != '0 && exp_r <= 12'sd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags  <= '0;
         inex_q <= 1'b0;
      end else begin
         if (accept) begin
            flags  <= '0;
            inex_q <= 1'b0;
         end
         if (state == S_ALIGN && lost_al)       inex_q <= 1'b1;
         if (state == S_NORM && m[47] && m[0])  inex_q <= 1'b1;
         if (state == S_PACK)
            flags <= {nan_q, ovf, unf, inex_q | (!nan_q && lost_pk)};
      end
   end
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq: a driver issues ops and pushes reference results,
// a monitor pops and compares on every done pulse.
module tb_fpu_seq;
   localparam int K = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] a_i = '0, b_i = '0;
   logic        busy, done;
   logic [31:0] result;
`ifdef FPU_FLAGS_EN
   logic [3:0]  flags;
`endif

   fpu_seq #(.MUL_BITS_PER_CYCLE(K)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
      .busy(busy), .done(done),
`ifdef FPU_FLAGS_EN
      .flags(flags),
`endif
      .result(result));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          start_cyc;
      bit          ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: value-level IEEE-like arithmetic with flush-to-zero and truncation.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] res, output int lat, output bit ovf);
      bit     hf = o[1];
      int     fw = hf ? 10 : 23;
      int     emx = hf ? 31 : 255;
      int     bias = hf ? 15 : 127;
      bit     sa, sb, s, s_big, s_sml;
      int     ea, eb, e, e_big, e_sml, dd;
      longint fa, fb, ma, mb, m, m_big, m_sml, sm;
      if (hf) begin
         sa = x[15]; ea = int'(x[14:10]); fa = longint'(x[9:0]);
         sb = y[15]; eb = int'(y[14:10]); fb = longint'(y[9:0]);
      end else begin
         sa = x[31]; ea = int'(x[30:23]); fa = longint'(x[22:0]);
         sb = y[31]; eb = int'(y[30:23]); fb = longint'(y[22:0]);
      end
      ovf = 1'b0;
      if (ea == emx || eb == emx) begin
         res = hf ? 32'h0000_7E00 : 32'h7FC0_0000;
         lat = 2;
         return;
      end
      ma = (ea == 0) ? 0 : ((longint'(1) << fw) | fa);
      mb = (eb == 0) ? 0 : ((longint'(1) << fw) | fb);
      if (o[0]) begin
         s = sa ^ sb;
         if (ma == 0 || mb == 0) begin
            m = 0; e = 0; lat = 2;
         end else begin
            m = ma * mb;
            e = ea + eb - bias;
            if (m >= (longint'(1) << (2 * fw + 1))) begin m = m >> 1; e++; end
            m = m >> fw;
            lat = 3 + (hf ? (11 + K - 1) / K : 24 / K);
         end
      end else begin
         if (eb > ea || (eb == ea && mb > ma)) begin
            s_big = sb; e_big = eb; m_big = mb; s_sml = sa; e_sml = ea; m_sml = ma;
         end else begin
            s_big = sa; e_big = ea; m_big = ma; s_sml = sb; e_sml = eb; m_sml = mb;
         end
         dd = e_big - e_sml;
         sm = (dd >= fw + 3) ? 0 : (m_sml >> dd);
         m  = (s_big == s_sml) ? (m_big + sm) : (m_big - sm);
         s  = s_big;
         e  = e_big;
         lat = 5;
         if (m == 0) begin
            if (s_big != s_sml) s = 1'b0;
         end else if (m >= (longint'(1) << (fw + 1))) begin
            m = m >> 1; e++;
         end else begin
            while (m < (longint'(1) << fw)) begin m = m << 1; e--; lat++; end
         end
      end
      if (m == 0 || e <= 0)
         res = hf ? {16'b0, s, 15'b0} : {s, 31'b0};
      else if (e >= emx) begin
         res = hf ? {16'b0, s, 5'h1F, 10'b0} : {s, 8'hFF, 23'b0};
         ovf = 1'b1;
      end else
         res = hf ? {16'b0, s, 5'(e), 10'(m)} : {s, 8'(e), 23'(m)};
   endfunction

   function automatic logic [31:0] rnd_opnd(input bit hf);
      int          sel = $urandom_range(0, 15);
      logic [31:0] v = $urandom;
      if (hf) begin
         v = {16'b0, v[15:0]};
         if (sel > 1) v[14:10] = 5'($urandom_range(12, 18));
      end else if (sel > 1) begin
         v[30:23] = 8'($urandom_range(120, 134));
      end
      return v;
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || done) && n < 200) begin @(negedge clk); n++; end
      if (busy || done) begin
         checks++; errors++;
         $display("FAIL wait_idle: busy %b done %b still set after 200 cycles", busy, done);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      wait_idle();
      op_i = o; a_i = x; b_i = y; start = 1'b1;
      ref_model(o, x, y, e.res, e.lat, e.ovf);
      e.start_cyc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op_i  = 2'($urandom);
      a_i   = $urandom;
      b_i   = $urandom;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_done: got done=1 with result %h, expected no done", result);
            end else begin
               e = sb_q.pop_front();
               check("result", result, e.res);
               check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
               check("busy_at_done", 32'(busy), 32'd0);
`ifdef FPU_FLAGS_EN
               check("overflow_flag", 32'(flags[2]), 32'(e.ovf));
`endif
            end
         end
      end
   end

   initial begin : driver
      logic [1:0]  o;
      logic [31:0] x, y;
      int          n;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      reset = 1'b0;

      issue(2'b00, 32'h3F80_0000, 32'h4000_0000);
      issue(2'b01, 32'h3FC0_0000, 32'h4000_0000);
      issue(2'b10, 32'h0000_3C00, 32'h0000_3C00);
      issue(2'b11, 32'h0000_4000, 32'h0000_4200);
      issue(2'b00, 32'h3F80_0000, 32'hBF80_0000);
      issue(2'b01, 32'h7F00_0000, 32'h7F00_0000);
      issue(2'b00, 32'h7F80_0001, 32'h3F80_0000);
      issue(2'b00, 32'h3F80_0001, 32'hBF80_0000);
      issue(2'b01, 32'h0000_0000, 32'hC000_0000);

      // starts while busy and during the done cycle must be ignored
      issue(2'b00, 32'h3F80_0000, 32'h4000_0000);
      op_i = 2'b01; a_i = 32'h4040_0000; b_i = 32'h4040_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 50) begin @(negedge clk); n++; end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done within 50 cycles, expected one");
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // reset in the middle of an FMUL
      wait_idle();
      op_i = 2'b01; a_i = 32'h3FC0_0000; b_i = 32'h4000_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 300; i++) begin
         o = 2'($urandom);
         x = rnd_opnd(o[1]);
         y = rnd_opnd(o[1]);
         if (!o[0] && $urandom_range(0, 3) == 0)
            y = o[1] ? (x ^ 32'h0000_8000 ^ 32'($urandom_range(0, 63)))
                     : (x ^ 32'h8000_0000 ^ 32'($urandom_range(0, 4095)));
         issue(o, x, y);
      end

      n = 0;
      while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: got %0d outstanding ops, expected 0", sb_q.size());
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Multicycle floating-point execute unit, directly downstream of the instruction decoder; consumes its FPUW strobe and the instruction's Funct[1:0].
- Executes FADD, FMUL, FADDH and FMULH on register operands.
- Returns the result to the ResultSrc=2'b10 writeback mux with a start/busy/done handshake, so the main FSM can stall in its FP-execute state.

Parameters:
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle in the iterative mantissa multiply; legal values 1, 2, 4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch strobe (decoder FPUW).
- op  in  2  Funct[1:0]: 00 FADD, 01 FMUL, 10 FADDH (half), 11 FMULH (half).
- a  in  32  operand A; half ops use a[15:0].
- b  in  32  operand B; half ops use b[15:0].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  result; half results are zero-extended to 32 bits.

Behaviour:
- Reset values: busy=0, done=0, result=0, FSM in IDLE. Reset mid-operation aborts the operation; no done is produced.
- start is accepted only in IDLE. start while busy or during the done cycle is ignored.
- Operands and op are latched on acceptance; later input changes do not matter.
- FSM states: IDLE -> UNPACK -> (ALIGN -> ADD | MUL) -> NORM -> PACK -> IDLE.
  - done is asserted in the cycle PACK registers result. busy drops in that same cycle.
- Formats:
  - Single: 1/8/23, bias 127.
  - Half: 1/5/10, bias 15.
  - Hidden bit is restored for normal inputs.
- UNPACK:
  - Exponent 0 (zero or denormal) is flushed to signed zero.
  - Exponent all-ones on either operand: result = canonical NaN (0x7FC00000 single, 0x00007E00 half). Go straight to PACK.
- ALIGN (add):
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference in one cycle. Differences >= mantissa width + 2 make it zero.
  - Shifted-out bits are discarded.
- ADD: add magnitudes if signs match, otherwise subtract. Exact zero difference gives +0.
- MUL:
  - Sign = XOR of operand signs.
  - Exponent = ea + eb − bias.
  - Mantissa product is computed by iterative shift-add, MUL_BITS_PER_CYCLE bits per cycle: 24/MUL_BITS_PER_CYCLE cycles single, ceil(11/MUL_BITS_PER_CYCLE) half.
  - Either operand zero: skip MUL and produce signed zero.
- NORM:
  - Carry-out: shift right 1, exponent +1.
  - Leading zeros: shift left one bit per cycle until the hidden bit is 1. Each step decrements the exponent.
- Rounding: truncation (round toward zero) only.
- PACK:
  - Exponent >= all-ones: signed infinity.
  - Exponent <= 0: signed zero.
  - Otherwise pack normally.
- result holds its value until the next done or reset.
- Latency (start to done, MUL_BITS_PER_CYCLE=1):
  - FMUL: 27 cycles.
  - FMULH: 14 cycles.
  - Add ops: 5 + number of left-normalise steps.

Optional Feature:
- FPU_FLAGS_EN defined:
  - Adds output port flags[3:0] = {invalid, overflow, underflow, inexact}.
  - flags is updated in the done cycle, set with result, and cleared at reset or on the next accepted start.
  - inexact = any nonzero bit discarded by align, product truncation, or a NORM right-shift.
- FPU_FLAGS_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- FADD a=0x3F800000, b=0x40000000 -> result=0x40400000, done pulses once, busy low after.
- FMUL a=0x3FC00000, b=0x40000000 (MUL_BITS_PER_CYCLE=1) -> result=0x40400000 exactly 27 cycles after start.
- FADDH a=0x3C00, b=0x3C00 -> result=0x00004000; FMULH a=0x4000, b=0x4200 -> result=0x00004600.
- FADD a=0x3F800000, b=0xBF800000 -> result=0x00000000.
- Exceptional inputs:
  - FMUL 0x7F000000 × 0x7F000000 -> 0x7F800000 (overflow flag if FPU_FLAGS_EN).
  - FADD 0x7F800001 + 0x3F800000 -> 0x7FC00000.
- Handshake and reset:
  - start re-asserted while busy -> ignored, single done with the first op's result.
  - reset asserted mid-FMUL -> busy=0, done=0, result=0 next cycle, no later done.
